// File: rtl/uart_ctl_pkg.sv
// Shared types and widths for the UART TX/RX word controllers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: TX_STATE_T (TX controller FSM), RX_STATE_T (RX controller FSM),
// BYTE_W (UART character width), WORD_W (application word width).
package uart_ctl_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // TX controller: idle -> MSB write -> LSB write -> inter-word gap.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE_MSB = 2'd1,
        ST_WRITE_LSB = 2'd2,
        ST_GAP       = 2'd3
    } TX_STATE_T;

    // RX controller: waits for MSB, then LSB, then presents {MSB, LSB}.
    typedef enum logic [1:0] {
        RX_ST_WAIT_MSB = 2'd0,
        RX_ST_WAIT_LSB = 2'd1,
        RX_ST_DONE     = 2'd2
    } RX_STATE_T;

endpackage

// File: rtl/uart_tx_ctl.sv
// Splits a 16-bit word into MSB then LSB single-cycle writes into the UART TX FIFO.
// Latency: handshake edge E, MSB strobe at E+1, LSB strobe at E+3, tx_ready back at E+4+FRAME_GAP.
// Backpressure: stalls in the current write state while tx_full=1; tx_ready low outside idle.
// Ports: clk/rst (async active-high); tx_word/tx_valid/tx_ready word handshake;
//        tx_full FIFO full flag; wr_uart/w_data FIFO write; words_sent wrapping word count.
// Option: define UART_TX_ON_CHANGE_EN to also start a send whenever tx_word differs
//         from the last word sent.
module uart_tx_ctl
    import uart_ctl_pkg::*;
#(
    parameter int FRAME_GAP = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] tx_word,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [BYTE_W-1:0] w_data,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int GAP_W = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;

    TX_STATE_T         r_state;
    logic [WORD_W-1:0] r_word;
    logic              r_wr_uart;
    logic [BYTE_W-1:0] r_w_data;
    logic [CNT_W-1:0]  r_words_sent;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              w_start;
    logic              w_can_write;

`ifdef UART_TX_ON_CHANGE_EN
    logic [WORD_W-1:0] r_last_word;
    assign w_start = tx_valid || (tx_word != r_last_word);
`else
    assign w_start = tx_valid;
`endif

    // The !r_wr_uart term leaves one cycle after every strobe for the FIFO's
    // full flag to reflect that write before the next one is attempted.
    assign w_can_write = !tx_full && !r_wr_uart;

    assign tx_ready   = (r_state == ST_IDLE);
    assign wr_uart    = r_wr_uart;
    assign w_data     = r_w_data;
    assign words_sent = r_words_sent;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_word       <= '0;
            r_wr_uart    <= 1'b0;
            r_w_data     <= '0;
            r_words_sent <= '0;
            r_gap_cnt    <= '0;
`ifdef UART_TX_ON_CHANGE_EN
            r_last_word  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wr_uart <= 1'b0;
                    if (w_start) begin
                        r_word  <= tx_word;
                        r_state <= ST_WRITE_MSB;
                    end
                end
                ST_WRITE_MSB: begin
                    if (w_can_write) begin
                        r_wr_uart <= 1'b1;
                        r_w_data  <= r_word[WORD_W-1:BYTE_W];
                        r_state   <= ST_WRITE_LSB;
                    end else begin
                        r_wr_uart <= 1'b0;
                    end
                end
                ST_WRITE_LSB: begin
                    if (w_can_write) begin
                        r_wr_uart    <= 1'b1;
                        r_w_data     <= r_word[BYTE_W-1:0];
                        r_words_sent <= r_words_sent + CNT_W'(1);
`ifdef UART_TX_ON_CHANGE_EN
                        r_last_word  <= r_word;
`endif
                        if (FRAME_GAP == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            // The LSB strobe cycle is not itself idle, so the
                            // counter covers FRAME_GAP whole cycles after it.
                            r_gap_cnt <= GAP_W'(FRAME_GAP);
                            r_state   <= ST_GAP;
                        end
                    end else begin
                        r_wr_uart <= 1'b0;
                    end
                end
                ST_GAP: begin
                    r_wr_uart <= 1'b0;
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_wr_uart <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Directed bench for uart_tx_ctl (FRAME_GAP=4, CNT_W=8).
// Latency: checks strobe timing E+1/E+3 and tx_ready return at E+8.
// Backpressure: holds tx_full to stall the MSB write and checks the resumed sequence.
module tb_uart_tx_ctl;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [15:0] tx_word  = 16'h0000;
    logic        tx_valid = 1'b0;
    logic        tx_full  = 1'b0;
    logic        tx_ready;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic [7:0]  words_sent;

    int errors = 0;
    int checks = 0;

    // Strobe monitor: every write is logged; back-to-back strobes are counted.
    int         strobe_cnt = 0;
    int         dbl_cnt    = 0;
    logic       prev_wr    = 1'b0;
    logic [7:0] seen_q[$];

    uart_tx_ctl #(.FRAME_GAP(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_word    (tx_word),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .w_data     (w_data),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_uart === 1'b1) begin
            strobe_cnt++;
            seen_q.push_back(w_data);
            if (prev_wr === 1'b1) dbl_cnt++;
        end
        prev_wr = wr_uart;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a word for exactly one edge (the handshake edge E); returns at E+1ns.
    task automatic send_start(input logic [15:0] w);
        tx_word  = w;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (tx_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: tx_ready=%b after %0d cycles, required 1", name, tx_ready, budget);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (tx_ready !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        checks++; if (wr_uart !== 1'b0)     begin errors++; $display("FAIL reset_wr: got %b want 0", wr_uart); end
        checks++; if (w_data !== 8'h00)     begin errors++; $display("FAIL reset_data: got %h want 00", w_data); end
        checks++; if (words_sent !== 8'd0)  begin errors++; $display("FAIL reset_cnt: got %0d want 0", words_sent); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        send_start(16'hABCD);                      // edge E
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: tx_ready=%b want 0", tx_ready); end
        tick();                                    // E+1
        checks++; if (wr_uart !== 1'b1 || w_data !== 8'hAB) begin errors++; $display("FAIL basic_msb: wr=%b data=%h want 1/AB", wr_uart, w_data); end
        tick();                                    // E+2
        checks++; if (wr_uart !== 1'b0) begin errors++; $display("FAIL basic_gap_strobe: wr=%b want 0", wr_uart); end
        tick();                                    // E+3
        checks++; if (wr_uart !== 1'b1 || w_data !== 8'hCD) begin errors++; $display("FAIL basic_lsb: wr=%b data=%h want 1/CD", wr_uart, w_data); end
        checks++; if (words_sent !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", words_sent); end
        repeat (4) tick();                         // E+7
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_early: tx_ready=%b at E+7 want 0", tx_ready); end
        tick();                                    // E+8
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: tx_ready=%b at E+8 want 1", tx_ready); end
    endtask

    // Stalls the MSB write with tx_full and changes tx_word after the handshake.
    task automatic test_backpressure;
        int base;
        tx_full = 1'b1;
        send_start(16'hABCD);
        tx_word = 16'h1234;
        base = strobe_cnt;
        repeat (10) tick();
        checks++; if (strobe_cnt != base) begin errors++; $display("FAIL bp_stall: %0d strobes while full, want 0", strobe_cnt - base); end
        checks++; if (tx_ready !== 1'b0)  begin errors++; $display("FAIL bp_ready: tx_ready=%b want 0", tx_ready); end
        tx_full = 1'b0;
        tick();
        checks++; if (wr_uart !== 1'b1 || w_data !== 8'hAB) begin errors++; $display("FAIL bp_msb: wr=%b data=%h want 1/AB", wr_uart, w_data); end
        tick();
        checks++; if (wr_uart !== 1'b0) begin errors++; $display("FAIL bp_no_double: wr=%b want 0", wr_uart); end
        tick();
        checks++; if (wr_uart !== 1'b1 || w_data !== 8'hCD) begin errors++; $display("FAIL bp_lsb: wr=%b data=%h want 1/CD", wr_uart, w_data); end
        tx_word = 16'hABCD;
        wait_ready("bp_done", 20);
        checks++; if (words_sent !== 8'd2) begin errors++; $display("FAIL bp_cnt: got %0d want 2", words_sent); end
    endtask

    task automatic test_reset_mid;
        send_start(16'h5A5A);
        tick();                                    // MSB written, now in LSB state
        tick();
        #2;
        rst = 1'b1;
        #1;                                        // no clock edge in this window
        checks++; if (wr_uart !== 1'b0)    begin errors++; $display("FAIL mid_rst_wr: got %b want 0", wr_uart); end
        checks++; if (w_data !== 8'h00)    begin errors++; $display("FAIL mid_rst_data: got %h want 00", w_data); end
        checks++; if (words_sent !== 8'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", words_sent); end
        checks++; if (tx_ready !== 1'b1)   begin errors++; $display("FAIL mid_rst_ready: got %b want 1", tx_ready); end
        tick();
        rst = 1'b0;
        tick();
        seen_q.delete();
        send_start(16'h00FF);
        wait_ready("mid_rst_resend", 20);
        checks++;
        if (seen_q.size() != 2) begin
            errors++; $display("FAIL mid_rst_bytes: %0d strobes want 2", seen_q.size());
        end else if (seen_q[0] !== 8'h00 || seen_q[1] !== 8'hFF) begin
            errors++; $display("FAIL mid_rst_bytes: got %h %h want 00 FF", seen_q[0], seen_q[1]);
        end
        checks++; if (words_sent !== 8'd1) begin errors++; $display("FAIL mid_rst_cnt2: got %0d want 1", words_sent); end
    endtask

    // words_sent starts at 1 here; 255 more words wrap it to 0, one more gives 1.
    task automatic test_wrap;
        int base;
        base = strobe_cnt;
        for (int i = 0; i < 256; i++) begin
            wait_ready("wrap_ready", 20);
            if (i == 255) begin
                checks++; if (words_sent !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", words_sent); end
            end
            send_start(16'(i));
        end
        wait_ready("wrap_last", 20);
        checks++; if (words_sent !== 8'd1)         begin errors++; $display("FAIL wrap_cnt: got %0d want 1", words_sent); end
        checks++; if (strobe_cnt - base != 512)    begin errors++; $display("FAIL wrap_strobes: got %0d want 512", strobe_cnt - base); end
        checks++; if (dbl_cnt != 0)                begin errors++; $display("FAIL no_consecutive_wr: %0d back-to-back strobes want 0", dbl_cnt); end
    endtask

`ifdef UART_TX_ON_CHANGE_EN
    task automatic test_on_change;
        tx_word = 16'h0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen_q.delete();
        repeat (5) tick();
        checks++; if (seen_q.size() != 0) begin errors++; $display("FAIL chg_same: %0d strobes want 0", seen_q.size()); end
        tx_word = 16'h0055;
        repeat (20) tick();
        checks++;
        if (seen_q.size() != 2) begin
            errors++; $display("FAIL chg_send: %0d strobes want 2", seen_q.size());
        end else if (seen_q[0] !== 8'h00 || seen_q[1] !== 8'h55) begin
            errors++; $display("FAIL chg_send: got %h %h want 00 55", seen_q[0], seen_q[1]);
        end
        repeat (20) tick();
        checks++; if (seen_q.size() != 2) begin errors++; $display("FAIL chg_hold: %0d strobes want 2", seen_q.size()); end
    endtask
`else
    task automatic test_on_change;
        int base;
        base = strobe_cnt;
        tx_word = 16'h3C3C;
        repeat (20) tick();
        checks++; if (strobe_cnt != base) begin errors++; $display("FAIL no_valid_no_send: %0d strobes want 0", strobe_cnt - base); end
        checks++; if (tx_ready !== 1'b1)  begin errors++; $display("FAIL no_valid_ready: got %b want 1", tx_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_on_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
